// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
//   Two requesters share one serial double-dabble binary-to-BCD converter.
//   A round-robin arbiter grants one requester from IDLE and latches its
//   8-bit operand. SHIFT then runs eight add-3/shift steps, and DONE pulses
//   ack to the served requester for one cycle. Each conversion takes
//   10 cycles from grant to the next possible grant.
//
// Optional feature (macro BCD_CLAMP99_EN):
//   When this macro is defined, results above 99 load 0/9/9 and raise
//   overflow. When it is undefined, the three-digit result is always exact
//   and overflow is tied low.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : synchronous, active-high
//   req[1:0]   : level requests, bit i = requester i
//   data0/1    : 8-bit binary operands of requester 0 / 1
//   ack[1:0]   : one-cycle completion pulse to the served requester
//   busy       : high in SHIFT and DONE
//   res_owner  : requester whose result is on the digit outputs
//   dig_hund/dig_tens/dig_ones : BCD result digits
//   overflow   : clamp indicator (always 0 unless BCD_CLAMP99_EN)
module bcd_conv_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] ack,
  output logic       busy,
  output logic       res_owner,
  output logic [3:0] dig_hund,
  output logic [3:0] dig_tens,
  output logic [3:0] dig_ones,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        owner_r;        // requester currently being converted
  logic        last_r;         // requester served most recently
  logic [7:0]  op_r;           // operand shift register
  logic [11:0] bcd_r;          // BCD accumulator: hundreds/tens/ones
  logic [3:0]  cnt_r;          // completed shift steps
  logic        grant_s;
  logic        grant_owner_s;
  logic        last_shift_s;
  logic [11:0] bcd_adj_s;
  logic [11:0] bcd_shift_s;
  logic [7:0]  op_shift_s;

  logic [1:0]  ack_r;
  logic        busy_r;
  logic        res_owner_r;
  logic [3:0]  dig_hund_r, dig_tens_r, dig_ones_r;

  // Double-dabble correction: add 3 to a nibble of 5 or more before shifting.
  function automatic logic [3:0] dabble(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      return nib + 4'd3;
    end else begin
      return nib;
    end
  endfunction

  // Next-state logic, round-robin grant, and last-shift detection.
  always_comb begin
    state_s       = state_r;
    grant_s       = 1'b0;
    grant_owner_s = 1'b0;
    last_shift_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req != 2'b00) begin
          grant_s = 1'b1;
          state_s = SHIFT;
          // With both requests high, serve the requester not served last.
          if (req == 2'b11) begin
            grant_owner_s = ~last_r;
          end else begin
            grant_owner_s = req[1];
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == 4'd7) begin
          last_shift_s = 1'b1;
          state_s      = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One double-dabble step; the hundreds nibble never exceeds 2, so it needs no correction.
  always_comb begin
    bcd_adj_s = {bcd_r[11:8], dabble(bcd_r[7:4]), dabble(bcd_r[3:0])};
    {bcd_shift_s, op_shift_s} = {bcd_adj_s, op_r} << 5'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Converter datapath: latch at grant, then shift during SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r <= 1'b0;
      last_r  <= 1'b1;   // requester 0 wins the first tie after reset
      op_r    <= 8'd0;
      bcd_r   <= 12'd0;
      cnt_r   <= 4'd0;
    end else if (grant_s) begin
      owner_r <= grant_owner_s;
      last_r  <= grant_owner_s;
      op_r    <= grant_owner_s ? data1 : data0;
      bcd_r   <= 12'd0;
      cnt_r   <= 4'd0;
    end else if (state_r == SHIFT) begin
      bcd_r   <= bcd_shift_s;
      op_r    <= op_shift_s;
      cnt_r   <= cnt_r + 4'd1;
    end else begin
      bcd_r   <= bcd_r;
      op_r    <= op_r;
      cnt_r   <= cnt_r;
    end
  end

  // Handshake outputs: ack is high only in DONE; busy spans grant through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r  <= 2'b00;
      busy_r <= 1'b0;
    end else begin
      ack_r <= 2'b00;
      if (last_shift_s) begin
        ack_r <= owner_r ? 2'b10 : 2'b01;
      end else begin
        ack_r <= 2'b00;
      end
      if (grant_s) begin
        busy_r <= 1'b1;
      end else if (state_r == DONE) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

`ifdef BCD_CLAMP99_EN
  logic overflow_r;

  // Result registers with two-digit clamping; loaded only on the final shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_owner_r <= 1'b0;
      dig_hund_r  <= 4'd0;
      dig_tens_r  <= 4'd0;
      dig_ones_r  <= 4'd0;
      overflow_r  <= 1'b0;
    end else if (last_shift_s) begin
      res_owner_r <= owner_r;
      if (bcd_shift_s[11:8] != 4'd0) begin
        dig_hund_r <= 4'd0;
        dig_tens_r <= 4'd9;
        dig_ones_r <= 4'd9;
        overflow_r <= 1'b1;
      end else begin
        dig_hund_r <= 4'd0;
        dig_tens_r <= bcd_shift_s[7:4];
        dig_ones_r <= bcd_shift_s[3:0];
        overflow_r <= 1'b0;
      end
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;
`else
  // Result registers holding the exact three-digit result; loaded only on the final shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_owner_r <= 1'b0;
      dig_hund_r  <= 4'd0;
      dig_tens_r  <= 4'd0;
      dig_ones_r  <= 4'd0;
    end else if (last_shift_s) begin
      res_owner_r <= owner_r;
      dig_hund_r  <= bcd_shift_s[11:8];
      dig_tens_r  <= bcd_shift_s[7:4];
      dig_ones_r  <= bcd_shift_s[3:0];
    end else begin
      res_owner_r <= res_owner_r;
    end
  end

  assign overflow = 1'b0;
`endif

  assign ack       = ack_r;
  assign busy      = busy_r;
  assign res_owner = res_owner_r;
  assign dig_hund  = dig_hund_r;
  assign dig_tens  = dig_tens_r;
  assign dig_ones  = dig_ones_r;

endmodule
